arbiter_rr_8: RTL and testbench

ARBITER_RR_8 -- requirements
Module: arbiter_rr_8

---
 rtl/arbiter_rr_8.sv | 80 ++++++++
 tb/tb_arbiter_rr_8.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/arbiter_rr_8.sv
// Eight-way round-robin arbiter with a single held grant.
// Grants are released by done, by the request dropping, or after MAX_HOLD cycles.
module arbiter_rr_8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [7:0] LIMIT    = 8'(MAX_HOLD);
   localparam bit         LIMIT_EN = (MAX_HOLD != 0);

   state_t     state;
   logic [2:0] ptr;
   logic [7:0] hold;

   logic [2:0] winner;
   logic       any;
   logic       owner_req;
   logic       at_limit;
   logic       release_now;

   // Scan from the far end so the lowest offset from ptr is the last to win.
   always_comb begin
      winner = '0;
      any    = |req;
      for (int i = 7; i >= 0; i--) begin
         if (req[ptr + 3'(i)]) winner = ptr + 3'(i);
      end
   end

   assign owner_req   = req[gnt_idx];
   assign at_limit    = LIMIT_EN && (hold == LIMIT - 8'd1);
   assign release_now = done | ~owner_req | at_limit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         hold      <= '0;
         gnt       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (any) begin
                  state     <= GRANT;
                  gnt       <= 8'd1 << winner;
                  gnt_idx   <= winner;
                  gnt_valid <= 1'b1;
                  hold      <= '0;
               end
            end
            GRANT: begin
               if (release_now) begin
                  state     <= IDLE;
                  gnt       <= '0;
                  gnt_valid <= 1'b0;
                  ptr       <= gnt_idx + 3'd1;
                  timeout   <= at_limit & ~done & owner_req;
               end else begin
                  hold <= hold + 8'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arbiter_rr_8.sv
// Directed bench for arbiter_rr_8: a vector table plus hand-written
// multi-cycle sequences; a second instance runs with forced release off.
module tb_arbiter_rr_8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       done;

   logic [7:0] gnt, gnt_n;
   logic [2:0] gnt_idx, gnt_idx_n;
   logic       gnt_valid, gnt_valid_n;
   logic       timeout, timeout_n;

   int checks = 0;
   int errors = 0;

   arbiter_rr_8 #(.MAX_HOLD(4)) dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .gnt(gnt), .gnt_idx(gnt_idx),
      .gnt_valid(gnt_valid), .timeout(timeout)
   );

   arbiter_rr_8 #(.MAX_HOLD(0)) dut_n (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .gnt(gnt_n), .gnt_idx(gnt_idx_n),
      .gnt_valid(gnt_valid_n), .timeout(timeout_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic       done;
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       vld;
      logic       to;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic [7:0] q,
                               input logic d, input logic [7:0] g,
                               input logic [2:0] i, input logic v,
                               input logic t);
      vec_t x;
      x.rst = r; x.req = q; x.done = d;
      x.gnt = g; x.idx = i; x.vld = v; x.to = t;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Drive at negedge, sample 1ns after the next posedge, return at negedge.
   task automatic step(input string nm, input vec_t v);
      rst  = v.rst;
      req  = v.req;
      done = v.done;
      @(posedge clk);
      #1;
      chk({nm, ".gnt"}, gnt, v.gnt);
      chk({nm, ".idx"}, 8'(gnt_idx), 8'(v.idx));
      chk({nm, ".vld"}, 8'(gnt_valid), 8'(v.vld));
      chk({nm, ".to"}, 8'(timeout), 8'(v.to));
      @(negedge clk);
   endtask

   // Grant invariants on both instances, every cycle.
   always @(negedge clk) begin
      if (!$onehot0(gnt) || gnt_valid !== (|gnt) ||
          (gnt_valid && gnt !== (8'd1 << gnt_idx))) begin
         errors++;
         $display("FAIL onehot: gnt %h idx %0d vld %b", gnt, gnt_idx, gnt_valid);
      end
      if (!$onehot0(gnt_n) || gnt_valid_n !== (|gnt_n)) begin
         errors++;
         $display("FAIL onehot_n: gnt %h vld %b", gnt_n, gnt_valid_n);
      end
   end

   initial begin
      rst = 1'b1; req = '0; done = 1'b0;

      // Requesters 2 and 5 alternate; done pulses release each grant.
      tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 8'h24, 0, 8'h04, 2, 1, 0));
      tbl.push_back(mk(0, 8'h24, 1, 8'h00, 2, 0, 0));
      tbl.push_back(mk(0, 8'h24, 0, 8'h20, 5, 1, 0));
      tbl.push_back(mk(0, 8'h24, 1, 8'h00, 5, 0, 0));
      tbl.push_back(mk(0, 8'h24, 0, 8'h04, 2, 1, 0));
      tbl.push_back(mk(0, 8'h24, 1, 8'h00, 2, 0, 0));
      tbl.push_back(mk(0, 8'h24, 0, 8'h20, 5, 1, 0));
      tbl.push_back(mk(0, 8'h24, 1, 8'h00, 5, 0, 0));
      // done in idle is ignored; request drop releases; ptr 6 wraps to 0.
      tbl.push_back(mk(0, 8'h00, 1, 8'h00, 5, 0, 0));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 5, 0, 0));
      tbl.push_back(mk(0, 8'h01, 1, 8'h01, 0, 1, 0));
      tbl.push_back(mk(0, 8'h01, 0, 8'h01, 0, 1, 0));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0));
      // Reset wins over a full request; then a full sweep 0..7 and wrap to 0.
      tbl.push_back(mk(1, 8'hFF, 0, 8'h00, 0, 0, 0));
      for (int k = 0; k < 8; k++) begin
         tbl.push_back(mk(0, 8'hFF, 0, 8'd1 << k, 3'(k), 1, 0));
         tbl.push_back(mk(0, 8'hFF, 1, 8'h00, 3'(k), 0, 0));
      end
      tbl.push_back(mk(0, 8'hFF, 0, 8'h01, 0, 1, 0));

      @(negedge clk);
      foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

      // Forced release after 4 cycles, timeout pulse, re-grant of 3.
      step("mh_rst", mk(1, 8'h00, 0, 8'h00, 0, 0, 0));
      for (int c = 0; c < 4; c++) begin
         step($sformatf("mh_hold%0d", c), mk(0, 8'h08, 0, 8'h08, 3, 1, 0));
         chk("mh_nolimit.gnt", gnt_n, 8'h08);
      end
      step("mh_tout", mk(0, 8'h08, 0, 8'h00, 3, 0, 1));
      chk("mh_nolimit.gnt", gnt_n, 8'h08);
      chk("mh_nolimit.to", 8'(timeout_n), 8'h00);
      step("mh_regrant", mk(0, 8'h08, 0, 8'h08, 3, 1, 0));
      chk("mh_nolimit.gnt", gnt_n, 8'h08);

      // Limit, done and request drop all at one edge: one plain release.
      step("sim_rst", mk(1, 8'h00, 0, 8'h00, 0, 0, 0));
      for (int c = 0; c < 4; c++)
         step($sformatf("sim_hold%0d", c), mk(0, 8'h02, 0, 8'h02, 1, 1, 0));
      step("sim_rel", mk(0, 8'h00, 1, 8'h00, 1, 0, 0));
      step("sim_ptr", mk(0, 8'hFF, 0, 8'h04, 2, 1, 0));

      // Limit together with done only: still no timeout.
      step("dn_rst", mk(1, 8'h00, 0, 8'h00, 0, 0, 0));
      for (int c = 0; c < 3; c++)
         step($sformatf("dn_hold%0d", c), mk(0, 8'h80, 0, 8'h80, 7, 1, 0));
      step("dn_last", mk(0, 8'h80, 0, 8'h80, 7, 1, 0));
      step("dn_rel", mk(0, 8'h80, 1, 8'h00, 7, 0, 0));
      step("dn_wrap", mk(0, 8'h81, 0, 8'h01, 0, 1, 0));

      // Reset in the middle of requester 6's grant.
      step("mr_rst", mk(1, 8'h00, 0, 8'h00, 0, 0, 0));
      step("mr_g6", mk(0, 8'h40, 0, 8'h40, 6, 1, 0));
      step("mr_hold", mk(0, 8'h41, 0, 8'h40, 6, 1, 0));
      step("mr_kill", mk(1, 8'h41, 0, 8'h00, 0, 0, 0));
      step("mr_g0", mk(0, 8'h41, 0, 8'h01, 0, 1, 0));

      // Other requests churn while 4 holds the grant.
      step("ch_rst", mk(1, 8'h00, 0, 8'h00, 0, 0, 0));
      step("ch_g4", mk(0, 8'h10, 0, 8'h10, 4, 1, 0));
      for (int c = 0; c < 3; c++) begin
         logic [7:0] r;
         r = 8'($urandom) | 8'h10;
         step($sformatf("ch_hold%0d", c), mk(0, r, 0, 8'h10, 4, 1, 0));
      end
      step("ch_done", mk(0, 8'hEF, 1, 8'h00, 4, 0, 0));
      step("ch_next", mk(0, 8'h0F, 0, 8'h01, 0, 1, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
